i2c_master: RTL and testbench
=============================

# i2c_master

Single-byte I2C bus master, the initiating end of the team's two-wire link, driving the same `i2c_sda`/`i2c_scl` lines that the slave blocks respond on. On a one-cycle `start` request it performs one transaction:
- START condition
- 7-bit address plus R/W bit
- slave ACK check
- one data byte, written or read
- master NACK after a read byte
- STOP condition

Both lines are open-drain: the block drives them low or releases them (`z`).

## Interface
- `CLK_DIV`, default 4: system clocks per SCL quarter-period. Must be ≥2. One SCL bit = 4 quarters = 4·CLK_DIV clocks.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request. Sampled only when `busy`=0.
- `addr`  in  7  target slave address. Latched when `start` is accepted.
- `rw`  in  1  0 = write, 1 = read. Latched when `start` is accepted.
- `wdata`  in  8  write byte. Latched when `start` is accepted.
- `rdata`  out  8  byte read from the slave. Valid when `done`=1. Holds until the next read completes.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the transaction, including STOP, finishes.
- `nack`  out  1  set with `done` if the address or the write-data byte was not acknowledged. Cleared when the next `start` is accepted.
- `i2c_sda`  inout  1  open-drain data line.
- `i2c_scl`  inout  1  open-drain clock line.

## Operation
- Quarter tick generator: a counter from 0 to CLK_DIV-1 runs only while `busy`=1. It emits a tick on wrap. A 2-bit `phase` counter (0..3) advances on each tick.
- Bit cell:
  - phase 0: SCL low; SDA updated.
  - phase 1: SCL released.
  - phase 2: SCL high; SDA sampled at the end of the phase.
  - phase 3: SCL pulled low.
- FSM states: IDLE, START, ADDR, ACK1, WRITE, READ, ACK2, STOP.
  - IDLE: both lines released. When `start`=1, latch `addr`/`rw`/`wdata`, shift register = {addr,rw}, bit count = 7, then go to START.
  - START (4 quarters): SDA released and SCL released for q0–q1; SDA low at q2 while SCL stays high; SCL low at q3. Then ADDR.
  - ADDR (8 bit cells): drive shift register MSB first; release SDA on 1, pull low on 0. Then ACK1.
  - ACK1 (1 cell): SDA released; sample at phase 2.
    - Sampled 1: set `nack`, go to STOP.
    - Sampled 0 and `rw`=0: WRITE.
    - Sampled 0 and `rw`=1: READ.
  - WRITE (8 cells): drive `wdata` MSB first. Then ACK2, which samples; a 1 sets `nack`.
  - READ (8 cells): SDA released; shift in the sampled bit MSB first. Then ACK2, where the master releases SDA (NACK); `rdata` is loaded at the end of ACK2.
  - STOP (4 quarters): SDA low with SCL low at q0; SCL released at q1; SDA released at q2 while SCL is high; q3 idle-high. Then `done`=1 for one cycle, `busy`=0, back to IDLE.
- No clock stretching, no arbitration, no repeated start. The block never reads back `i2c_scl`.
- `start` while `busy`=1 is ignored. It is not queued.

## Timing
- Reset values: `busy`=0, `done`=0, `nack`=0, `rdata`=8'h00, SDA/SCL released, FSM=IDLE, counters=0.
- Reset asserted mid-transaction: both lines are released at the next edge. No STOP is generated, and no `done` pulse is produced.
- Let E be the edge at which `start` is accepted. `busy`=1 after E.
- Full transaction = 4 + 36 + 36 + 4 = 80 quarters.
  - `done` is high in the cycle ending at E + 80·CLK_DIV.
  - `busy` falls in the same cycle.
- Address NACK = 4 + 36 + 4 = 44 quarters, so `done` at E + 44·CLK_DIV. No data cells are clocked.
- The write-data NACK path still takes 80 quarters; STOP is always issued.
- `start` asserted in the same cycle as `done` is ignored. A new request is accepted from the next cycle.
- SDA changes only while SCL is low, except for the START/STOP edges described above.

## Test plan
- Write 0x55/0xAA, `CLK_DIV`=4, bus slave model ACKs:
  - SDA at SCL rising edges = 0xAA (addr 0x55, W), then 0xAA.
  - `done` at E+320, `nack`=0.
- Read from 0x55, slave returns 0x3C:
  - addr byte 0xAB on the bus.
  - Master releases SDA on the 18th bit.
  - `rdata`=0x3C with `done` at E+320.
- Address 0x12 with no slave (SDA pulled up): `nack`=1, `done` at E+176, STOP seen, no further SCL pulses.
- Write where the slave NACKs the data byte: `nack`=1, `done` at E+320, STOP present.
- `start` pulsed again at E+50 with different `addr`: ignored; the bus carries only the first transaction.
- Reset at E+200 during the data phase: lines released and `busy`=0 next cycle, no `done`. A fresh `start` then completes normally.

Source files
------------

// File: rtl/i2c_master.sv
// Single-byte I2C bus master: START, address+R/W, ACK check, one data byte
// written or read (master NACKs a read byte), STOP. Open-drain SDA/SCL.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  inout  logic       i2c_sda,
  inout  logic       i2c_scl
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRELAST = CW'(CLK_DIV - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK1,
    ST_WRITE,
    ST_READ,
    ST_ACK2,
    ST_STOP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_phase;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic            r_rw;
  logic [7:0]      r_wdata;
  logic            r_ackfail;
  logic [7:0]      r_rdata;
  logic            r_nack;
  logic            r_done;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [1:0]      w_phase_nxt;
  logic [7:0]      w_shift_nxt;
  logic [2:0]      w_bitcnt_nxt;
  logic            w_rw_nxt;
  logic [7:0]      w_wdata_nxt;
  logic            w_ackfail_nxt;
  logic [7:0]      w_rdata_nxt;
  logic            w_nack_nxt;
  logic            w_done_nxt;
  logic            w_tick;
  logic            w_sample;
  logic            w_cell_end;
  logic            w_scl_cell_low;
  logic            w_sda_low;
  logic            w_scl_low;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_phase   <= '0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_rw      <= 1'b0;
      r_wdata   <= '0;
      r_ackfail <= 1'b0;
      r_rdata   <= '0;
      r_nack    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_shift   <= w_shift_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_rw      <= w_rw_nxt;
      r_wdata   <= w_wdata_nxt;
      r_ackfail <= w_ackfail_nxt;
      r_rdata   <= w_rdata_nxt;
      r_nack    <= w_nack_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_phase_nxt   = r_phase;
    w_shift_nxt   = r_shift;
    w_bitcnt_nxt  = r_bitcnt;
    w_rw_nxt      = r_rw;
    w_wdata_nxt   = r_wdata;
    w_ackfail_nxt = r_ackfail;
    w_rdata_nxt   = r_rdata;
    w_nack_nxt    = r_nack;
    w_done_nxt    = 1'b0;
    w_sda_low     = 1'b0;
    w_scl_low     = 1'b0;

    w_tick         = (r_cnt == CNT_LAST);
    w_sample       = w_tick && (r_phase == 2'd2);
    w_cell_end     = w_tick && (r_phase == 2'd3);
    w_scl_cell_low = (r_phase == 2'd0) || (r_phase == 2'd3);

    if (r_state != ST_IDLE) begin
      w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        w_phase_nxt = r_phase + 2'd1;
      end
    end

    unique case (r_state)
      ST_IDLE: begin
        // r_done blocks a request arriving in the same cycle as the done pulse
        if (start && !r_done) begin
          w_state_nxt   = ST_START;
          w_cnt_nxt     = '0;
          w_phase_nxt   = '0;
          w_shift_nxt   = {addr, rw};
          w_bitcnt_nxt  = 3'd7;
          w_rw_nxt      = rw;
          w_wdata_nxt   = wdata;
          w_ackfail_nxt = 1'b0;
          w_nack_nxt    = 1'b0;
        end
      end

      ST_START: begin
        w_sda_low = (r_phase == 2'd2) || (r_phase == 2'd3);
        w_scl_low = (r_phase == 2'd3);
        if (w_cell_end) begin
          w_state_nxt = ST_ADDR;
        end
      end

      ST_ADDR, ST_WRITE: begin
        w_sda_low = ~r_shift[7];
        w_scl_low = w_scl_cell_low;
        if (w_cell_end) begin
          w_shift_nxt  = {r_shift[6:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt - 3'd1;
          if (r_bitcnt == 3'd0) begin
            w_state_nxt = (r_state == ST_ADDR) ? ST_ACK1 : ST_ACK2;
          end
        end
      end

      ST_ACK1: begin
        w_scl_low = w_scl_cell_low;
        if (w_sample) begin
          w_ackfail_nxt = i2c_sda;
        end
        if (w_cell_end) begin
          w_bitcnt_nxt = 3'd7;
          if (r_ackfail) begin
            w_state_nxt = ST_STOP;
          end else if (r_rw) begin
            w_state_nxt = ST_READ;
          end else begin
            w_state_nxt = ST_WRITE;
            w_shift_nxt = r_wdata;
          end
        end
      end

      ST_READ: begin
        w_scl_low = w_scl_cell_low;
        if (w_sample) begin
          w_shift_nxt = {r_shift[6:0], i2c_sda};
        end
        if (w_cell_end) begin
          w_bitcnt_nxt = r_bitcnt - 3'd1;
          if (r_bitcnt == 3'd0) begin
            w_state_nxt = ST_ACK2;
          end
        end
      end

      ST_ACK2: begin
        w_scl_low = w_scl_cell_low;
        if (w_sample && !r_rw) begin
          w_ackfail_nxt = i2c_sda;
        end
        if (w_cell_end) begin
          if (r_rw) begin
            w_rdata_nxt = r_shift;
          end
          w_state_nxt = ST_STOP;
        end
      end

      ST_STOP: begin
        w_sda_low = (r_phase == 2'd0) || (r_phase == 2'd1);
        w_scl_low = (r_phase == 2'd0);
        // finish one clock early so done's cycle ends exactly on the last quarter
        if ((r_phase == 2'd3) && (r_cnt == CNT_PRELAST)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_phase_nxt = '0;
          w_done_nxt  = 1'b1;
          w_nack_nxt  = r_ackfail;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign i2c_sda = w_sda_low ? 1'b0 : 1'bz;
  assign i2c_scl = w_scl_low ? 1'b0 : 1'bz;

  assign rdata = r_rdata;
  assign busy  = (r_state != ST_IDLE);
  assign done  = r_done;
  assign nack  = r_nack;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: behavioural slave on the bus, transaction
// timing from the accepting edge, bus bit capture and status checks.
module tb_i2c_master;

  logic       clk;
  logic       reset;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       nack;
  wire        sda;
  wire        scl;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // slave model state
  logic       cfg_ack_addr;
  logic       cfg_ack_data;
  logic [7:0] cfg_tx;
  logic       slv_low = 1'b0;
  int         bitidx = 0;
  int         starts = 0;
  int         stops = 0;
  int         scl_rises = 0;
  logic       bus_bits [0:31];

  pullup (sda);
  pullup (scl);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .addr    (addr),
    .rw      (rw),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .nack    (nack),
    .i2c_sda (sda),
    .i2c_scl (scl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge sda) if (scl === 1'b1) begin
    starts <= starts + 1;
    bitidx <= 0;
  end
  always @(posedge sda) if (scl === 1'b1) stops <= stops + 1;

  always @(posedge scl) begin
    if (bitidx < 32) bus_bits[bitidx] <= sda;
    bitidx    <= bitidx + 1;
    scl_rises <= scl_rises + 1;
  end

  always @(negedge scl) begin
    if (bitidx == 8)
      slv_low <= cfg_ack_addr;
    else if (bitidx >= 9 && bitidx <= 16 && bus_bits[7] === 1'b1)
      slv_low <= ~cfg_tx[16 - bitidx];
    else if (bitidx == 17 && bus_bits[7] === 1'b0)
      slv_low <= cfg_ack_data;
    else
      slv_low <= 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bus_byte(input int off);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = bus_bits[off+i];
    return b;
  endfunction

  int e_cyc, lat, s0, p0, r0;
  logic saw_done;

  // Issue one request and wait (bounded) for done; optionally inject a second
  // start at E+inj_at or assert reset at E+rst_at.
  task automatic run_txn(input logic [6:0] a, input logic rwb, input logic [7:0] wd,
                         input int inj_at, input int rst_at);
    int n;
    @(negedge clk);
    addr = a; rw = rwb; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e_cyc = cyc; s0 = starts; p0 = stops; r0 = scl_rises;
    check("busy_up", busy, 1);
    check("nack_clr", nack, 0);
    saw_done = 1'b0; lat = 0; n = 0;
    while (!saw_done && n < 2000) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done) begin
        saw_done = 1'b1;
        lat = cyc + 1 - e_cyc;
      end else if (rst_at != 0 && cyc - e_cyc == rst_at - 1) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end else if (inj_at != 0 && cyc - e_cyc == inj_at - 1) begin
        addr = 7'h12; rw = 1'b1; wdata = 8'h00; start = 1'b1;
      end
    end
    if (!saw_done) check("done_timeout", 0, 1);
  endtask

  initial begin
    int r_hold;
    reset = 1'b1; start = 1'b0; addr = '0; rw = 1'b0; wdata = '0;
    cfg_ack_addr = 1'b1; cfg_ack_data = 1'b1; cfg_tx = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // write 0x55 <- 0xAA, slave acks
    run_txn(7'h55, 1'b0, 8'hAA, 0, 0);
    check("wr_lat", lat, 320);
    check("wr_nack", nack, 0);
    check("wr_addr_byte", bus_byte(0), 8'hAA);
    check("wr_ack1", bus_bits[8], 0);
    check("wr_data_byte", bus_byte(9), 8'hAA);
    check("wr_starts", starts - s0, 1);
    check("wr_stops", stops - p0, 1);
    check("wr_scl_rises", scl_rises - r0, 19);
    @(negedge clk);
    check("wr_done_pulse", done, 0);
    check("wr_busy_low", busy, 0);

    // read from 0x55, slave returns 0x3C
    cfg_tx = 8'h3C;
    run_txn(7'h55, 1'b1, 8'h00, 0, 0);
    check("rd_lat", lat, 320);
    check("rd_addr_byte", bus_byte(0), 8'hAB);
    check("rd_bus_data", bus_byte(9), 8'h3C);
    check("rd_master_nack", bus_bits[17], 1);
    check("rd_rdata", rdata, 8'h3C);
    check("rd_nack", nack, 0);
    check("rd_stops", stops - p0, 1);

    // address 0x12, nobody answers
    cfg_ack_addr = 1'b0;
    run_txn(7'h12, 1'b0, 8'h77, 0, 0);
    check("an_lat", lat, 176);
    check("an_nack", nack, 1);
    check("an_addr_byte", bus_byte(0), 8'h24);
    check("an_stops", stops - p0, 1);
    check("an_scl_rises", scl_rises - r0, 10);
    r_hold = scl_rises;
    repeat (60) @(negedge clk);
    check("an_scl_quiet", scl_rises, r_hold);
    cfg_ack_addr = 1'b1;

    // data byte NACKed by the slave
    cfg_ack_data = 1'b0;
    run_txn(7'h55, 1'b0, 8'h0F, 0, 0);
    check("dn_lat", lat, 320);
    check("dn_nack", nack, 1);
    check("dn_data_byte", bus_byte(9), 8'h0F);
    check("dn_stops", stops - p0, 1);
    check("dn_rdata_hold", rdata, 8'h3C);
    cfg_ack_data = 1'b1;

    // second start at E+50 ignored; start in the done cycle ignored too
    run_txn(7'h55, 1'b0, 8'h33, 50, 0);
    check("ig_lat", lat, 320);
    check("ig_addr_byte", bus_byte(0), 8'hAA);
    check("ig_data_byte", bus_byte(9), 8'h33);
    check("ig_starts", starts - s0, 1);
    check("ig_scl_rises", scl_rises - r0, 19);
    addr = 7'h12; rw = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ig_done_cycle_start", busy, 0);
    repeat (3) @(negedge clk);

    // reset during the data phase, then a fresh transaction
    run_txn(7'h55, 1'b0, 8'hAA, 0, 200);
    check("rs_busy", busy, 0);
    check("rs_scl", scl, 1);
    check("rs_sda", sda, 1);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("rs_no_done", seen, 0);
    end
    run_txn(7'h55, 1'b0, 8'h5A, 0, 0);
    check("rs2_lat", lat, 320);
    check("rs2_nack", nack, 0);
    check("rs2_data_byte", bus_byte(9), 8'h5A);
    check("rs2_stops", stops - p0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
